// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher datapath and its controller.
// Provides the block/byte types, the controller state encoding, the inverse
// S-box table and the GF(2^8) arithmetic helpers (reduction polynomial 0x11b).
package aes_pkg;

  localparam int unsigned NB     = 4;        // columns per state
  localparam int unsigned NBYTES = 4 * NB;   // bytes per block
  localparam int unsigned BLK_W  = 32 * NB;  // bits per block

  typedef logic [7:0]         byte_t;
  typedef logic [0:BLK_W-1]   blk_t;         // byte k = bits [8k:8k+7], column-major

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Inverse S-box lookup.
  function automatic byte_t inv_sbox(input byte_t b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x in GF(2^8), reducing by 0x11b.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply; folds to a small XOR network for constant a.
  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational single AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (unless skip_mix).
// Ports:
//   state    current 128-bit state, column-major bytes
//   rkey     round key applied in this round
//   skip_mix high for the final round (no InvMixColumns)
//   next_c   resulting state (combinational)
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:BLK_W-1] state,
  input  logic [0:BLK_W-1] rkey,
  input  logic             skip_mix,
  output logic [0:BLK_W-1] next_c
);

  byte_t ark [NBYTES];

  // Shift/substitute/key-add: new[r][c] takes old[r][(c - r) mod 4].
  always_comb begin : p_sub_key
    for (int k = 0; k < int'(NBYTES); k++) begin
      ark[k] = 8'h00;
    end
    for (int k = 0; k < int'(NBYTES); k++) begin
      automatic int row = k % 4;
      automatic int col = k / 4;
      automatic int src = 4 * ((col + 4 - row) % 4) + row;
      ark[k] = inv_sbox(state[8*src +: 8]) ^ rkey[8*k +: 8];
    end
  end

  // Column mix with coefficients {0e,0b,0d,09}, bypassed on the final round.
  always_comb begin : p_mix
    next_c = '0;
    for (int c = 0; c < int'(NB); c++) begin
      automatic byte_t a0 = ark[4*c];
      automatic byte_t a1 = ark[4*c+1];
      automatic byte_t a2 = ark[4*c+2];
      automatic byte_t a3 = ark[4*c+3];
      if (skip_mix) begin
        next_c[32*c +: 32] = {a0, a1, a2, a3};
      end else begin
        next_c[32*c    +: 8] = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
        next_c[32*c+8  +: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
        next_c[32*c+16 +: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
        next_c[32*c+24 +: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
      end
    end
  end

endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES inverse cipher: one inverse round per clock over a shared
// round datapath, framed by valid/ready handshakes on both sides.
// One block in flight; a block occupies the engine for nr+2 cycles.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   ciphertext handshake (in_ready high only in IDLE)
//   in_data             ciphertext, byte k = in_data[8k:8k+7]
//   key_d               expanded key schedule, round key r = key_d[128r +: 128]
//   out_valid/out_ready plaintext handshake
//   out_data            plaintext, held while out_valid && !out_ready
//   busy                high while a block is in ROUND or DONE
module aes_dec_iter_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned nk = 4,
  parameter int unsigned nr = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:127]            in_data,
  input  logic [0:128*(nr+1)-1]   key_d,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:127]            out_data,
  output logic                    busy
);

  localparam int unsigned RC_W = $clog2(nr + 1);

  generate
    if (nr != nk + 6) begin : g_bad_cfg
      $error("aes_dec_iter_ctrl: nr must equal nk+6");
    end
  endgenerate

  fsm_e             st;
  logic [RC_W-1:0]  rc;
  blk_t             state_q;
  blk_t             rk_last;
  blk_t             rk_cur;
  blk_t             rnd_c;
  logic             last_c;

  // Key schedule is consumed unregistered; the caller holds it for the block.
  assign rk_last = key_d[BLK_W*nr +: BLK_W];
  assign rk_cur  = key_d[BLK_W*32'(rc) +: BLK_W];
  assign last_c  = (rc == '0);

  aes_inv_round u_round (
    .state    (state_q),
    .rkey     (rk_cur),
    .skip_mix (last_c),
    .next_c   (rnd_c)
  );

  // Controller: sequencing, round counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      rc        <= '0;
      state_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_data ^ rk_last;
            rc       <= RC_W'(nr - 1);
            st       <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          state_q <= rnd_c;
          if (!last_c) begin
            rc <= rc - RC_W'(1);
          end else begin
            st        <= DONE;
            out_valid <= 1'b1;
            out_data  <= rnd_c;
          end
        end
        DONE: begin
          // in_ready rises only after the handshake edge, so no same-cycle reload.
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Directed bench for aes_dec_iter_ctrl using FIPS-197 appendix C vectors.
module tb_aes_dec_iter_ctrl;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;
  logic out_ready;
  logic [0:127] in_data;

  logic in_valid, in_ready, out_valid, busy;
  logic [0:127] out_data;
  logic iv192, ir192, ov192, busy192;
  logic [0:127] od192;
  logic iv256, ir256, ov256, busy256;
  logic [0:127] od256;

  logic [0:1407] key128;
  logic [0:1663] key192;
  logic [0:1919] key256;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_dec_iter_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key_d(key128), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  aes_dec_iter_ctrl #(.nk(6), .nr(12)) u_d192 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv192), .in_ready(ir192),
    .in_data(in_data), .key_d(key192), .out_valid(ov192),
    .out_ready(out_ready), .out_data(od192), .busy(busy192)
  );

  aes_dec_iter_ctrl #(.nk(8), .nr(14)) u_d256 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv256), .in_ready(ir256),
    .in_data(in_data), .key_d(key256), .out_valid(ov256),
    .out_ready(out_ready), .out_data(od256), .busy(busy256)
  );

  // ---------------- reference GF / key expansion ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward S-box from its definition: GF inverse followed by the affine map.
  function automatic logic [7:0] fsbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {fsbox(w[31:24]), fsbox(w[23:16]), fsbox(w[15:8]), fsbox(w[7:0])};
  endfunction

  function automatic logic [0:1919] expand(input logic [0:255] key, input int nkw);
    logic [0:1919] w;
    logic [31:0]   t;
    logic [7:0]    rcon;
    w = '0;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (nkw + 7); i++) begin
      if (i < nkw) begin
        w[32*i +: 32] = key[32*i +: 32];
      end else begin
        t = w[32*(i-1) +: 32];
        if (i % nkw == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nkw > 6 && i % nkw == 4) begin
          t = subw(t);
        end
        w[32*i +: 32] = w[32*(i-nkw) +: 32] ^ t;
      end
    end
    return w;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [127:0] got);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 128'(exp_q.size()), 128'd1);
    else chk(tag, got, exp_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a block on the main DUT until accepted; returns the accept cycle.
  task automatic send(input logic [127:0] d, input logic [127:0] e, output int acc_cyc);
    bit acc;
    acc = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("accept", 128'(acc), 128'd1);
    exp_q.push_back(e);
    acc_cyc = cyc;
  endtask

  task automatic wait_out(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else step();
    end
    chk({tag, "_seen"}, 128'(seen), 128'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [0:1919] full;
    int a;
    bit acc;
    bit seen;
    int nacc;
    int nout;
    int nvalid;
    int t [3];
    logic [127:0] hold;

    rst_n = 1'b0;
    in_valid = 1'b0;
    iv192 = 1'b0;
    iv256 = 1'b0;
    out_ready = 1'b1;
    in_data = '0;

    full = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    key128 = full[0:1407];
    full = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    key192 = full[0:1663];
    full = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    key256 = full;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single AES-128 block, no backpressure.
    send(CT128, PT, a);
    chk("c1_busy", 128'(busy), 128'd1);
    wait_out("c1");
    chk("c1_latency", 128'(cyc - a), 128'd10);
    sb_pop("c1_data", out_data);
    step();
    chk("c1_pulse", 128'(out_valid), 128'd0);
    chk("c1_in_ready", 128'(in_ready), 128'd1);
    chk("c1_busy_end", 128'(busy), 128'd0);

    // Backpressure: output held stable, no new accept.
    out_ready = 1'b0;
    send(CT128, PT, a);
    wait_out("bp");
    hold = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", out_data, hold);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    sb_pop("bp_result", out_data);
    out_ready = 1'b1;
    step();
    chk("bp_release", 128'(out_valid), 128'd0);
    chk("bp_in_ready_after", 128'(in_ready), 128'd1);

    // A second block offered mid-round must be ignored.
    send(CT128, PT, a);
    repeat (3) step();
    in_data = 128'hdeadbeef0badf00d0123456789abcdef;
    in_valid = 1'b1;
    chk("ign_in_ready", 128'(in_ready), 128'd0);
    repeat (2) step();
    in_valid = 1'b0;
    wait_out("ign");
    sb_pop("ign_data", out_data);
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) nvalid++;
    end
    chk("ign_no_extra", 128'(nvalid), 128'd0);

    // Asynchronous reset in the middle of the rounds.
    send(CT128, PT, a);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_out_data", out_data, 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(CT128, PT, a);
    wait_out("post_rst");
    chk("post_rst_latency", 128'(cyc - a), 128'd10);
    sb_pop("post_rst_data", out_data);
    step();

    // Back-to-back with in_valid held high.
    in_data = CT128;
    in_valid = 1'b1;
    nacc = 0;
    nout = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    for (int i = 0; i < 80 && nout < 3; i++) begin
      acc = in_ready && in_valid;
      step();
      if (acc) begin
        t[nacc] = cyc;
        nacc++;
        exp_q.push_back(PT);
        if (nacc == 3) in_valid = 1'b0;
      end
      if (out_valid) begin
        sb_pop("b2b_data", out_data);
        nout++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_outputs", 128'(nout), 128'd3);
    chk("b2b_space01", 128'(t[1] - t[0]), 128'd12);
    chk("b2b_space12", 128'(t[2] - t[1]), 128'd12);
    step();

    // AES-192 build.
    in_data = CT192;
    iv192 = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = ir192;
      step();
    end
    iv192 = 1'b0;
    a = cyc;
    chk("c2_accept", 128'(acc), 128'd1);
    exp_q.push_back(PT);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ov192) seen = 1'b1;
      else step();
    end
    chk("c2_seen", 128'(seen), 128'd1);
    chk("c2_latency", 128'(cyc - a), 128'd12);
    sb_pop("c2_data", od192);
    step();

    // AES-256 build.
    in_data = CT256;
    iv256 = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = ir256;
      step();
    end
    iv256 = 1'b0;
    a = cyc;
    chk("c3_accept", 128'(acc), 128'd1);
    exp_q.push_back(PT);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ov256) seen = 1'b1;
      else step();
    end
    chk("c3_seen", 128'(seen), 128'd1);
    chk("c3_latency", 128'(cyc - a), 128'd14);
    sb_pop("c3_data", od256);
    step();

    chk("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
